// File: rtl/fetch_unit.sv
// Instruction fetch unit: accepts fetch addresses, issues word-aligned reads to instruction
// memory, pairs in-order responses with their fetch pc, and queues the results for downstream.
// A credit rule bounds requests plus outstanding reads plus queued entries to DEPTH, so the
// instruction queue can never overflow. A flush drops all pending work; reads that were
// already granted are counted in a discard counter and their responses are silently dropped.
module fetch_unit #(
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // Program-counter side
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic                pc_valid_i,
  output logic                pc_ready_o,
  input  logic                flush_i,
  // Instruction memory side
  output logic                mem_req_o,
  output logic [PC_WIDTH-1:0] mem_addr_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [PC_WIDTH-1:0] mem_rdata_i,
  // Downstream side
  output logic [PC_WIDTH-1:0] instr_o,
  output logic [PC_WIDTH-1:0] instr_pc_o,
  output logic                instr_fault_o,
  output logic                instr_valid_o,
  input  logic                instr_ready_i
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;  // holds 0..DEPTH
  localparam int unsigned CrdW = PtrW + 3;  // holds outstanding + queued + request

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;  // unaligned pc of the pending request
  logic [CntW-1:0]     outst_q, outst_d;
  logic [CntW-1:0]     discard_q, discard_d;

  // Side FIFO: pc and fault flag of each granted, not-yet-returned, non-discarded read
  logic [PC_WIDTH-1:0] side_pc_q    [DEPTH];
  logic                side_fault_q [DEPTH];
  logic [PtrW:0]       side_wptr_q, side_rptr_q;

  // Instruction queue
  logic [PC_WIDTH-1:0] q_data_q  [DEPTH];
  logic [PC_WIDTH-1:0] q_pc_q    [DEPTH];
  logic                q_fault_q [DEPTH];
  logic [PtrW:0]       q_wptr_q, q_rptr_q;

  logic                grant, accept;
  logic                rv_live, rv_use, rv_drop;
  logic                side_push, side_pop, side_empty;
  logic                q_wr, q_pop, q_empty, q_full;
  logic [PtrW:0]       q_count;
  logic [CrdW-1:0]     credits;

  // Handshake decode and credit accounting
  always_comb begin
    grant      = mem_req_o && mem_gnt_i;
    q_count    = q_wptr_q - q_rptr_q;
    q_empty    = (q_wptr_q == q_rptr_q);
    q_full     = (q_wptr_q[PtrW] != q_rptr_q[PtrW]) &&
                 (q_wptr_q[PtrW-1:0] == q_rptr_q[PtrW-1:0]);
    side_empty = (side_wptr_q == side_rptr_q);
    credits    = CrdW'(outst_q) + CrdW'(q_count) + CrdW'(mem_req_o);
    pc_ready_o = !rst_i && !flush_i && (!mem_req_o || mem_gnt_i) &&
                 (credits < CrdW'(DEPTH));
    accept     = pc_valid_i && pc_ready_o;
    // A response with nothing outstanding is stray and ignored entirely
    rv_live    = mem_rvalid_i && (outst_q != '0);
    rv_use     = rv_live && !flush_i && (discard_q == '0);
    rv_drop    = rv_live && !rv_use;
    side_push  = grant && !flush_i;
    side_pop   = rv_use;
    q_wr       = rv_use;
    q_pop      = instr_valid_o && instr_ready_i && !flush_i;
  end

  // Request FSM next state: issue on accept, hold until granted, drop on flush
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    req_pc_d = req_pc_q;
    if (accept) begin
      state_d  = StReq;
      addr_d   = {pc_i[PC_WIDTH-1:2], 2'b00};
      req_pc_d = pc_i;
    end else if (grant || flush_i) begin
      state_d = StIdle;
    end
  end

  // Outstanding-read and discard counters
  always_comb begin
    outst_d = outst_q;
    if (grant && !rv_live) begin
      outst_d = outst_q + CntW'(1);
    end else if (!grant && rv_live) begin
      outst_d = outst_q - CntW'(1);
    end
    discard_d = discard_q;
    if (flush_i) begin
      // Everything still in flight after this cycle must be dropped on return
      discard_d = outst_d;
    end else if (rv_drop) begin
      discard_d = discard_q - CntW'(1);
    end
  end

  // Control state and FIFO pointers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      req_pc_q    <= '0;
      outst_q     <= '0;
      discard_q   <= '0;
      side_wptr_q <= '0;
      side_rptr_q <= '0;
      q_wptr_q    <= '0;
      q_rptr_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      req_pc_q  <= req_pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      if (flush_i) begin
        side_wptr_q <= '0;
        side_rptr_q <= '0;
        q_wptr_q    <= '0;
        q_rptr_q    <= '0;
      end else begin
        if (side_push) side_wptr_q <= side_wptr_q + 1'b1;
        if (side_pop)  side_rptr_q <= side_rptr_q + 1'b1;
        if (q_wr)      q_wptr_q    <= q_wptr_q + 1'b1;
        if (q_pop)     q_rptr_q    <= q_rptr_q + 1'b1;
      end
    end
  end

  // FIFO storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge clk_i) begin
    if (side_push) begin
      side_pc_q[side_wptr_q[PtrW-1:0]]    <= req_pc_q;
      side_fault_q[side_wptr_q[PtrW-1:0]] <= (req_pc_q[1:0] != 2'b00);
    end
    if (q_wr) begin
      q_data_q[q_wptr_q[PtrW-1:0]]  <= mem_rdata_i;
      q_pc_q[q_wptr_q[PtrW-1:0]]    <= side_pc_q[side_rptr_q[PtrW-1:0]];
      q_fault_q[q_wptr_q[PtrW-1:0]] <= side_fault_q[side_rptr_q[PtrW-1:0]];
    end
  end

  // Outputs; the head fields read as zero whenever the queue is empty
  always_comb begin
    mem_req_o     = (state_q == StReq);
    mem_addr_o    = addr_q;
    instr_valid_o = !q_empty;
    instr_o       = instr_valid_o ? q_data_q[q_rptr_q[PtrW-1:0]]  : '0;
    instr_pc_o    = instr_valid_o ? q_pc_q[q_rptr_q[PtrW-1:0]]    : '0;
    instr_fault_o = instr_valid_o ? q_fault_q[q_rptr_q[PtrW-1:0]] : 1'b0;
  end

  a_q_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(q_wr && q_full && !q_pop));

  a_side_not_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    !(side_pop && side_empty));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic. Expected instructions are
// derived from accepted pcs (every accepted pc yields one instruction, in order, unless a flush
// intervenes) and checked by a separate monitor whenever downstream pops an entry.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] pc_i = '0;
  logic        pc_valid_i = 1'b0;
  logic        pc_ready_o;
  logic        flush_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_fault_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;

  fetch_unit #(.PC_WIDTH(32), .DEPTH(2)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pc_i         (pc_i),
    .pc_valid_i   (pc_valid_i),
    .pc_ready_o   (pc_ready_o),
    .flush_i      (flush_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .instr_fault_o(instr_fault_o),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
  } pend_t;

  exp_t        exp_q[$];   // expected instructions, in order
  logic [31:0] req_q[$];   // accepted pcs awaiting a memory grant
  pend_t       pend_q[$];  // granted reads awaiting a response

  int          n_tests = 0;
  int          n_fail = 0;
  int          n_pops = 0;
  int unsigned cyc = 0;
  int          gnt_force = 1;  // -1: random, 0/1: forced
  int          rv_force = 1;
  int unsigned gnt_pct = 50;
  int unsigned rv_pct = 50;
  logic        stray = 1'b0;
  logic        last_ready, last_accept;
  exp_t        mon_e;

  // Instruction memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h0000_0013;
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F96;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock cycle: drive memory inputs, record handshakes, advance to just after the edge
  task automatic step();
    logic g, rv;
    g = (gnt_force >= 0) ? gnt_force[0] : ($urandom_range(99) < gnt_pct);
    rv = 1'b0;
    if (pend_q.size() > 0 && pend_q[0].cyc < cyc)
      rv = (rv_force >= 0) ? rv_force[0] : ($urandom_range(99) < rv_pct);
    mem_gnt_i = g;
    if (stray) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hDEAD_BEEF;
    end else begin
      mem_rvalid_i = rv;
      mem_rdata_i  = rv ? pend_q[0].data : $urandom();
    end
    #1;
    last_ready  = pc_ready_o;
    last_accept = pc_valid_i && pc_ready_o;
    if (rst_i) begin
      chk("ready_in_reset", {63'd0, pc_ready_o}, 64'd0);
      exp_q.delete();
      req_q.delete();
      pend_q.delete();
    end else begin
      if (mem_req_o && mem_gnt_i) begin
        if (req_q.size() == 0) begin
          chk("unexpected_request", {32'd0, mem_addr_o}, 64'd0);
        end else begin
          chk("grant_addr", {32'd0, mem_addr_o}, {32'd0, req_q[0][31:2], 2'b00});
          void'(req_q.pop_front());
        end
        pend_q.push_back('{cyc: cyc, data: mem_word(mem_addr_o)});
      end
      if (mem_rvalid_i && !stray) void'(pend_q.pop_front());
      if (flush_i) begin
        chk("ready_in_flush", {63'd0, pc_ready_o}, 64'd0);
        exp_q.delete();
        req_q.delete();
      end else if (last_accept) begin
        exp_q.push_back('{instr: mem_word({pc_i[31:2], 2'b00}), pc: pc_i,
                          fault: (pc_i[1:0] != 2'b00)});
        req_q.push_back(pc_i);
      end
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic drain();
    pc_valid_i    = 1'b0;
    flush_i       = 1'b0;
    instr_ready_i = 1'b1;
    gnt_force     = 1;
    rv_force      = 1;
    for (int i = 0; i < 12; i++) step();
    chk("drain_exp_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_valid_low", {63'd0, instr_valid_o}, 64'd0);
  endtask

  // Monitor: compare each popped head entry against the oldest expected instruction
  always @(negedge clk_i) begin
    if (!rst_i && !flush_i && instr_valid_o === 1'b1 && instr_ready_i) begin
      n_tests++;
      n_pops++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_instr: got instr=%h pc=%h, required no output",
                 instr_o, instr_pc_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (instr_o !== mon_e.instr || instr_pc_o !== mon_e.pc ||
            instr_fault_o !== mon_e.fault) begin
          n_fail++;
          $display("FAIL instr_out: got instr=%h pc=%h fault=%b, required instr=%h pc=%h fault=%b",
                   instr_o, instr_pc_o, instr_fault_o, mon_e.instr, mon_e.pc, mon_e.fault);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pcs[3];
    int          idx;
    logic [5:0]  rdy_log;
    logic        got;
    int          pops0;

    // Reset state
    pc_valid_i = 1'b1;
    pc_i       = 32'h1234_5678;
    step();
    step();
    chk("rst_mem_req", {63'd0, mem_req_o}, 64'd0);
    chk("rst_mem_addr", {32'd0, mem_addr_o}, 64'd0);
    chk("rst_valid", {63'd0, instr_valid_o}, 64'd0);
    chk("rst_instr", {instr_o, instr_pc_o}, 64'd0);
    chk("rst_fault", {63'd0, instr_fault_o}, 64'd0);
    rst_i = 1'b0;

    // Minimum latency: visible three cycles after accept
    instr_ready_i = 1'b1;
    pc_i = 32'hBFC0_0000;
    step();
    chk("lat_accept", {63'd0, last_accept}, 64'd1);
    pc_valid_i = 1'b0;
    chk("lat_req", {31'd0, mem_req_o, mem_addr_o}, {31'd0, 1'b1, 32'hBFC0_0000});
    step();
    chk("lat_c2_invalid", {63'd0, instr_valid_o}, 64'd0);
    step();
    chk("lat_c3_valid", {31'd0, instr_valid_o, instr_o}, {31'd0, 1'b1, 32'h0000_0013});
    chk("lat_c3_pc", {32'd0, instr_pc_o}, {32'd0, 32'hBFC0_0000});
    drain();

    // Back-pressure with DEPTH=2: two accepts, third after the first pop
    instr_ready_i = 1'b0;
    pcs = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008};
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      pc_valid_i = (idx < 3);
      pc_i = pcs[idx];
      step();
      rdy_log[c] = last_ready;
      if (last_accept) idx++;
    end
    chk("bp_accepts", 64'(idx), 64'd2);
    chk("bp_ready_log", {58'd0, rdy_log}, {58'd0, 6'b000011});
    instr_ready_i = 1'b1;
    step();
    chk("bp_ready_pop_cycle", {63'd0, last_ready}, 64'd0);
    instr_ready_i = 1'b0;
    step();
    chk("bp_third_accept", {63'd0, last_accept}, 64'd1);
    drain();

    // Flush with two granted reads in flight
    instr_ready_i = 1'b1;
    rv_force = 0;
    pc_valid_i = 1'b1;
    pc_i = 32'h0000_3000;
    step();
    pc_i = 32'h0000_3004;
    step();
    pc_valid_i = 1'b0;
    step();
    chk("fl_pending", 64'(pend_q.size()), 64'd2);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    rv_force = 1;
    pops0 = n_pops;
    pc_valid_i = 1'b1;
    pc_i = 32'h8000_0000;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      got = last_accept;
    end
    chk("fl_new_accept", {63'd0, got}, 64'd1);
    drain();
    chk("fl_single_output", 64'(n_pops - pops0), 64'd1);

    // Grant withheld for four cycles
    gnt_force = 0;
    pc_valid_i = 1'b1;
    pc_i = 32'h0000_1004;
    step();
    pc_i = 32'h0000_2008;
    for (int c = 0; c < 4; c++) begin
      chk("stall_req", {31'd0, mem_req_o, mem_addr_o}, {31'd0, 1'b1, 32'h0000_1004});
      step();
      chk("stall_ready", {63'd0, last_ready}, 64'd0);
    end
    gnt_force = 1;
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      step();
      got = last_accept;
    end
    chk("stall_release_accept", {63'd0, got}, 64'd1);
    drain();

    // Misaligned fetch
    pc_valid_i = 1'b1;
    pc_i = 32'hBFC0_0002;
    step();
    pc_valid_i = 1'b0;
    chk("mis_addr", {32'd0, mem_addr_o}, {32'd0, 32'hBFC0_0000});
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      step();
      got = instr_valid_o;
    end
    chk("mis_out", {31'd0, got, instr_pc_o}, {31'd0, 1'b1, 32'hBFC0_0002});
    chk("mis_fault", {63'd0, instr_fault_o}, 64'd1);
    drain();

    // Reset with a read outstanding, then a stray response
    rv_force = 0;
    pc_valid_i = 1'b1;
    pc_i = 32'h0000_0100;
    step();
    pc_valid_i = 1'b0;
    step();
    rst_i = 1'b1;
    pc_valid_i = 1'b1;
    step();
    chk("rst_mid_ready", {63'd0, last_ready}, 64'd0);
    rst_i = 1'b0;
    pc_valid_i = 1'b0;
    stray = 1'b1;
    step();
    stray = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stray_ignored", {63'd0, instr_valid_o}, 64'd0);
    end
    drain();

    // Randomized traffic
    gnt_force = -1;
    rv_force = -1;
    for (int i = 0; i < 1500; i++) begin
      if (i % 300 == 0) begin
        gnt_pct = $urandom_range(30, 100);
        rv_pct  = $urandom_range(30, 100);
      end
      pc_valid_i = ($urandom_range(99) < 70);
      pc_i = $urandom();
      if ($urandom_range(3) != 0) pc_i[1:0] = 2'b00;
      instr_ready_i = ($urandom_range(99) < 60);
      flush_i = ($urandom_range(99) < 3);
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
